// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 register
// window, and one packed window is emitted per interior pixel under valid/ready.
module sobel_window_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [9*PIX_W-1:0] m_window,
    output logic               m_first,
    output logic               m_last,
    output logic               frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] win [9];
    logic [PIX_W-1:0] nxt [9];
    logic [9*PIX_W-1:0] nxt_packed;

    logic accept;
    logic produce;
    logic col_last;
    logic row_last;

    assign s_ready  = !reset && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign produce  = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Window after this accept's shift; the output register captures it directly.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            nxt[k] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            nxt[3*r]   = win[3*r+1];
            nxt[3*r+1] = win[3*r+2];
        end
        nxt[2] = lb1[col];
        nxt[5] = lb0[col];
        nxt[8] = s_data;
        nxt_packed = '0;
        for (int k = 0; k < 9; k++) begin
            nxt_packed[PIX_W*k +: PIX_W] = nxt[k];
        end
    end

    // Line buffers and window carry no reset; rows 0-1 refill them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= s_data;
            for (int k = 0; k < 9; k++) begin
                win[k] <= nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            m_valid    <= 1'b0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            m_window   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && row_last && col_last;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (produce) begin
                m_valid  <= 1'b1;
                m_window <= nxt_packed;
                m_first  <= (row == RW'(2)) && (col == CW'(2));
                m_last   <= row_last && col_last;
            end else if (m_valid && m_ready) begin
                m_valid  <= 1'b0;
                m_window <= '0;
                m_first  <= 1'b0;
                m_last   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator for the Sobel datapath.
- Accepts raster-order pixels of a parametrised IMG_W x IMG_H frame over a valid/ready handshake.
- Holds two line buffers plus a 3x3 register window, and emits one packed 9-pixel window per interior pixel, with full backpressure.
- Sits between the frame memory read port and the Sobel core.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 640, pixels per line. Must be >= 3.
- IMG_H, 480, lines per frame. Must be >= 3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block can accept a pixel this cycle.
- s_data  input  PIX_W  input pixel, raster order.
- m_valid  output  1  window valid.
- m_ready  input  1  downstream accepts the window.
- m_window  output  9*PIX_W  packed window. Index k=3*r+c, with r=0 the top (oldest) line and c=0 the left (oldest) column. Pixel k occupies bits [PIX_W*(k+1)-1 : PIX_W*k].
- m_first  output  1  window centred on (row 1, col 1); qualified by m_valid.
- m_last  output  1  window centred on (row IMG_H-2, col IMG_W-2); qualified by m_valid.
- frame_done  output  1  one-cycle pulse, cycle after the last pixel of a frame is accepted.

Behaviour:
- Handshake and state:
  - accept = s_valid & s_ready.
  - s_ready = !reset & (!m_valid | m_ready), combinational.
  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the coordinate of the next accepted pixel.
  - Line buffers lb0 (previous line) and lb1 (line before that) each have depth IMG_W. They are inferable as simple dual-port RAM or registers.
- On accept at (row, col):
  - Window columns shift left (c0<-c1, c1<-c2).
  - New column c2 = {r0: lb1[col], r1: lb0[col], r2: s_data}.
  - lb1[col] <= lb0[col]; lb0[col] <= s_data.
- Counter update on accept:
  - col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next frame follows with no gap and no idle cycle is required.
- Window emit:
  - The accept at (row, col) produces a window iff row >= 2 and col >= 2. That window is centred on (row-1, col-1).
  - m_valid rises on the edge after that accept, so latency is 1 cycle from the accepting edge.
  - m_window, m_first and m_last are registered together with m_valid.
- Output register:
  - Cleared when m_valid & m_ready and no new window is produced.
  - Reloaded in the same cycle when m_ready and a producing accept coincide, giving zero bubbles at full throughput.
  - While m_valid & !m_ready, all m_* outputs hold stable and s_ready = 0.
- Window count:
  - Exactly (IMG_W-2)*(IMG_H-2) windows per frame; 304964 at the defaults.
  - No windows are produced during rows 0-1 or columns 0-1 of any row.
- Column wrap: stale pixels from the previous line enter the window at col 0/1. They are discarded because no window is emitted there.
- frame_done:
  - Pulses regardless of m_ready state.
  - At the defaults it coincides with m_valid rising for the m_last window.
- Reset values: m_valid=0, m_first=0, m_last=0, frame_done=0, m_window=0, col=0, row=0.
- Line buffer contents are not cleared. They need not be, because rows 0-1 overwrite them before use.
- Reset mid-frame: any pending window is dropped, and the next accepted pixel is treated as (0,0) of a new frame.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). No arithmetic overflow is possible.

Test Plan:
- IMG_W=5, IMG_H=4, pixel value = row*16+col, s_valid=1, m_ready=1 -> exactly 6 windows.
  - First window, k=0..8: 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22, with m_first=1.
  - Last window: 0x12..0x34, with m_last=1.
  - frame_done pulses once.
- Same frame with m_ready held 0 for 3 cycles after the first window -> m_window stays constant and s_ready=0 for those 3 cycles.
  - No pixel is lost; all 6 windows are still correct and in order.
- Random s_valid (50%) and random m_ready (50%), 5x4 frame -> output window sequence identical to the full-rate run.
- Two back-to-back 5x4 frames with different data (frame 2 = frame 1 + 0x80) -> frame 2 windows contain only frame 2 pixels.
  - Exactly 12 windows total, and 2 frame_done pulses.
- Reset asserted for 1 cycle after 9 pixels of a 5x4 frame, then a full frame -> no window output before the new frame's row 2, col 2.
  - Exactly 6 correct windows follow.
- Defaults 640x480, full rate -> exactly 304964 windows, with m_last on the 304964th.
  - Windows are checked against a software 3x3 extraction of the same data file.
